// File: rtl/audio_cfg_sequencer.sv
// Shadow/live configuration bank for the audio output path with a pop-free
// commit sequence: fade down, swap at a sample boundary, settle muted, fade up.
module audio_cfg_sequencer #(
    parameter int unsigned FADE_STEP_SAMPLES = 4,
    parameter int unsigned SETTLE_SAMPLES    = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_ce,
    input  logic        cfg_wr,
    input  logic [3:0]  cfg_addr,
    input  logic [15:0] cfg_data,
    input  logic        cfg_commit,
    output logic        busy,
    output logic [31:0] flt_rate,
    output logic [39:0] cx,
    output logic [7:0]  cx0,
    output logic [7:0]  cx1,
    output logic [7:0]  cx2,
    output logic [23:0] cy0,
    output logic [23:0] cy1,
    output logic [23:0] cy2,
    output logic [4:0]  att,
    output logic [1:0]  mix
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] FADE_LAST   = CNT_W'(FADE_STEP_SAMPLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_SAMPLES - 1);

    typedef struct packed {
        logic [31:0] flt_rate;
        logic [39:0] cx;
        logic [7:0]  cx0;
        logic [7:0]  cx1;
        logic [7:0]  cx2;
        logic [23:0] cy0;
        logic [23:0] cy1;
        logic [23:0] cy2;
        logic [4:0]  user_att;
        logic [1:0]  mix;
    } bank_t;

    localparam bank_t BANK_RST = '{
        flt_rate: 32'd7056000,
        cx:       40'd4258969,
        cx0:      8'd3,
        cx1:      8'd3,
        cx2:      8'd1,
        cy0:      24'hA123C9,
        cy1:      24'h5DBD9A,
        cy2:      24'hE11EA9,
        user_att: 5'd0,
        mix:      2'd0
    };

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FADE_OUT = 3'd1,
        APPLY    = 3'd2,
        SETTLE   = 3'd3,
        FADE_IN  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    bank_t            shadow;
    bank_t            live;
    logic [3:0]       ramp;
    logic [3:0]       ramp_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             pending;
    logic             pending_next;
    logic             busy_next;
    logic [4:0]       att_next;
    logic             apply;
    logic             fade_tick;
    logic             settle_tick;
    logic [3:0]       att_floor;

    assign fade_tick   = sample_ce && (cnt == FADE_LAST);
    assign settle_tick = sample_ce && (cnt == SETTLE_LAST);
    assign att_floor   = (ramp > live.user_att[3:0]) ? ramp : live.user_att[3:0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (cfg_commit || pending) state_next = FADE_OUT;
            FADE_OUT: if (fade_tick && (ramp == 4'hF)) state_next = APPLY;
            APPLY:    state_next = SETTLE;
            SETTLE:   if (settle_tick) state_next = FADE_IN;
            FADE_IN:  if (fade_tick && (ramp == 4'h0)) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Datapath/output next values
    always_comb begin
        ramp_next    = ramp;
        cnt_next     = cnt;
        pending_next = pending;
        apply        = 1'b0;
        case (state)
            IDLE:     if (state_next != IDLE) pending_next = 1'b0;
            FADE_OUT: if (fade_tick && (ramp != 4'hF)) ramp_next = ramp + 4'd1;
            APPLY:    apply = 1'b1;
            FADE_IN:  if (fade_tick && (ramp != 4'h0)) ramp_next = ramp - 4'd1;
            default:  ;
        endcase
        if ((state != IDLE) && cfg_commit) begin
            pending_next = 1'b1;
        end
        // Step counter restarts on every state entry and after each fade step
        if (state_next != state) begin
            cnt_next = '0;
        end else if (sample_ce && (state == FADE_OUT || state == FADE_IN)) begin
            cnt_next = fade_tick ? '0 : cnt + CNT_W'(1);
        end else if (sample_ce && state == SETTLE) begin
            cnt_next = cnt + CNT_W'(1);
        end
        busy_next = (state_next != IDLE) || pending_next;
        if (state == SETTLE || live.user_att[4]) begin
            att_next = 5'h10;
        end else begin
            att_next = {1'b0, att_floor};
        end
    end

    // Sequencer and bank registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ramp    <= '0;
            cnt     <= '0;
            pending <= 1'b0;
            busy    <= 1'b0;
            att     <= '0;
            shadow  <= BANK_RST;
            live    <= BANK_RST;
        end else begin
            ramp    <= ramp_next;
            cnt     <= cnt_next;
            pending <= pending_next;
            busy    <= busy_next;
            att     <= att_next;
            if (apply) begin
                live <= shadow;
            end
            if (cfg_wr) begin
                case (cfg_addr)
                    4'h0: shadow.flt_rate[15:0]  <= cfg_data;
                    4'h1: shadow.flt_rate[31:16] <= cfg_data;
                    4'h2: shadow.cx[15:0]        <= cfg_data;
                    4'h3: shadow.cx[31:16]       <= cfg_data;
                    4'h4: shadow.cx[39:32]       <= cfg_data[7:0];
                    4'h5: shadow.cx0             <= cfg_data[7:0];
                    4'h6: shadow.cx1             <= cfg_data[7:0];
                    4'h7: shadow.cx2             <= cfg_data[7:0];
                    4'h8: shadow.cy0[15:0]       <= cfg_data;
                    4'h9: shadow.cy0[23:16]      <= cfg_data[7:0];
                    4'hA: shadow.cy1[15:0]       <= cfg_data;
                    4'hB: shadow.cy1[23:16]      <= cfg_data[7:0];
                    4'hC: shadow.cy2[15:0]       <= cfg_data;
                    4'hD: shadow.cy2[23:16]      <= cfg_data[7:0];
                    4'hE: begin
                        shadow.user_att <= cfg_data[4:0];
                        shadow.mix      <= cfg_data[9:8];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign flt_rate = live.flt_rate;
    assign cx       = live.cx;
    assign cx0      = live.cx0;
    assign cx1      = live.cx1;
    assign cx2      = live.cx2;
    assign cy0      = live.cy0;
    assign cy1      = live.cy1;
    assign cy2      = live.cy2;
    assign mix      = live.mix;

endmodule

// File: doc/audio_cfg_sequencer.md
Name: audio_cfg_sequencer

Overview:
- Owns the live configuration of the audio output path: IIR filter coefficients (cx, cx0..cx2, cy0..cy2), filter rate, and the attenuation and mix controls.
- Host writes go into a shadow bank. On commit, the block fades the output down, swaps shadow into live at a sample boundary, waits for the filter to settle, then fades back up. This prevents pops on coefficient changes.
- Sits between the HPS/OSD config bus and the audio output block. It is clocked by the same clk and uses that block's sample_ce.

Parameters:
- FADE_STEP_SAMPLES, 4: number of sample_ce pulses per 1-step attenuation change during fades (range 1..255).
- SETTLE_SAMPLES, 256: number of sample_ce pulses held muted after the swap (range 1..65535).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sample_ce  in  1  one-cycle audio sample strobe.
- cfg_wr  in  1  write strobe to the shadow bank.
- cfg_addr  in  4  word address in the shadow bank.
- cfg_data  in  16  write data.
- cfg_commit  in  1  one-cycle request to apply the shadow bank.
- busy  out  1  high while a commit sequence is in progress or pending.
- flt_rate  out  32  live filter rate.
- cx  out  40  live coefficient.
- cx0, cx1, cx2  out  8 each  live coefficients.
- cy0, cy1, cy2  out  24 each  live coefficients.
- att  out  5  effective attenuation; bit4 = mute.
- mix  out  2  live mix.

Behaviour:
- Shadow map. Bits not listed for a word are ignored.
  - 0/1: flt_rate[15:0] / [31:16].
  - 2/3/4: cx[15:0] / [31:16] / [39:32] (from data[7:0]).
  - 5/6/7: cx0 / cx1 / cx2 (from data[7:0]).
  - 8/9: cy0[15:0] / [23:16]. A/B: cy1, same split. C/D: cy2, same split.
  - E: user_att = data[4:0], mix = data[9:8].
  - F: reserved; writes are ignored.
- Shadow writes take effect on the next cycle and are accepted in every state. Live registers change only in the APPLY state.
- Reset values:
  - Shadow and live are identical: flt_rate=7056000, cx=40'd4258969, cx0=3, cx1=3, cx2=1, cy0=24'hA123C9, cy1=24'h5DBD9A, cy2=24'hE11EA9, user_att=0, mix=0.
  - FSM=IDLE, ramp=0, busy=0, att=0, pending=0.
  - Reset mid-sequence aborts immediately. Live registers return to their reset values; no fade is performed.
- FSM states: IDLE, FADE_OUT, APPLY, SETTLE, FADE_IN.
  - IDLE: on cfg_commit (or pending=1), go to FADE_OUT next cycle and clear pending. busy is registered and rises the cycle after cfg_commit.
  - FADE_OUT: a step counter counts sample_ce. Each FADE_STEP_SAMPLES pulses, ramp increments. When ramp=15 and a further step elapses, go to APPLY.
  - APPLY: one cycle. Copy all shadow registers to live; ramp stays 15. Next state is SETTLE.
  - SETTLE: att is forced to 5'h10. After SETTLE_SAMPLES sample_ce pulses, go to FADE_IN.
  - FADE_IN: each FADE_STEP_SAMPLES pulses, ramp decrements. When ramp=0 and a further step elapses, go to IDLE. busy clears the same cycle the state becomes IDLE, unless pending=1.
  - The step counter resets on every state entry.
- att output (registered, 1-cycle latency from state/ramp):
  - In SETTLE: 5'h10.
  - Else if live user_att[4]=1: 5'h10.
  - Else: {1'b0, max(ramp, live user_att[3:0])}.
- cfg_commit in any non-IDLE state sets pending. Multiple commits collapse into one. pending re-runs the full sequence from IDLE, using the shadow contents at that time.
- cfg_wr and cfg_commit in the same cycle: the write lands first, and the commit applies the new value.
- sample_ce absent: the FSM stalls in its current fade/settle state; there is no timeout.
- Width rules: no arithmetic on coefficients; they are pure copies. The ramp is 4-bit and saturates at 0 and 15.

Test Plan:
- Reset, then read outputs -> all live values equal the reset constants, att=0, busy=0.
- Write addr 5 data 16'h0007, then commit; FADE_STEP_SAMPLES=4, SETTLE_SAMPLES=256 -> cx0 stays 3 until APPLY, becomes 7 after 64 sample_ce. att is 1,2,..15 every 4 samples, then 16 for 256 samples, then 15..0. busy falls after 64+256+64 sample_ce.
- Write addr E data 16'h0106 (att=6, mix=1), then commit -> after APPLY, mix=1. During FADE_IN, att floors at 6 and never goes below it. Final att=6.
- Commit, then issue a second commit and a write to addr 6 = 2 during SETTLE -> the first sequence completes. busy stays high and a second full sequence runs. cx1=2 appears at the second APPLY only.
- Assert reset during FADE_OUT with ramp=9 -> the next cycle shows state IDLE, att=0, busy=0, live values at reset constants.
- cfg_wr addr 4 data 16'hFF12 with cfg_commit in the same cycle -> cx[39:32]=8'h12 after APPLY; the upper data bits are ignored.
